lakespec_cfg_loader: RTL and testbench

Word-serial configuration loader that sits directly upstream of `lakespec`. It accepts the bitstream as a stream of `WORD_WIDTH`-bit words over a valid/ready handshake and assembles them in a shadow register. It then commits the image atomically to the wide `config_memory` vector that drives `lakespec`, and drives `lakespec`'s `flush` input for a fixed number of cycles after each commit.

---
 rtl/lakespec_cfg_loader.sv | 120 ++++++++++++
 tb/tb_lakespec_cfg_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lakespec_cfg_loader.sv
// Word-serial configuration loader: assembles config words in a shadow
// register and commits the full image atomically, then flushes lakespec.
module lakespec_cfg_loader #(
    parameter int unsigned CONFIG_MEMORY_SIZE = 512,
    parameter int unsigned WORD_WIDTH         = 32,
    parameter int unsigned FLUSH_CYCLES       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [WORD_WIDTH-1:0]         cfg_data,
    output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
    output logic                          flush_out,
    output logic                          cfg_loaded,
    output logic                          busy,
    output logic [$clog2((CONFIG_MEMORY_SIZE + WORD_WIDTH - 1) / WORD_WIDTH + 1)-1:0] word_idx
);

    localparam int unsigned NUM_WORDS = (CONFIG_MEMORY_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS + 1);
    localparam int unsigned CNT_W     = $clog2(FLUSH_CYCLES + 1);
    // Shadow is padded to whole words; bits above CONFIG_MEMORY_SIZE are never committed.
    localparam int unsigned PAD_W     = NUM_WORDS * WORD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } state_e;

    state_e                        state_q, state_d;
    logic [PAD_W-1:0]              shadow_q, shadow_d;
    logic [CONFIG_MEMORY_SIZE-1:0] cfg_mem_q, cfg_mem_d;
    logic                          loaded_q, loaded_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            cfg_mem_q <= '0;
            loaded_q  <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cfg_mem_q <= cfg_mem_d;
            loaded_q  <= loaded_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state and datapath update; restart in LOAD takes priority over word acceptance.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        cfg_mem_d = cfg_mem_q;
        loaded_d  = loaded_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d  = ST_LOAD;
                    idx_d    = '0;
                    shadow_d = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    idx_d    = '0;
                    shadow_d = '0;
                end else if (cfg_valid) begin
                    for (int k = 0; k < int'(NUM_WORDS); k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            shadow_d[k*WORD_WIDTH +: WORD_WIDTH] = cfg_data;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                cfg_mem_d = shadow_q[CONFIG_MEMORY_SIZE-1:0];
                loaded_d  = 1'b1;
                cnt_d     = CNT_W'(FLUSH_CYCLES);
                state_d   = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from registered state.
    assign cfg_ready     = (state_q == ST_LOAD);
    assign busy          = (state_q != ST_IDLE);
    assign flush_out     = (state_q == ST_FLUSH);
    assign config_memory = cfg_mem_q;
    assign cfg_loaded    = loaded_q;
    assign word_idx      = idx_q;

endmodule

// File: tb/tb_lakespec_cfg_loader.sv
// Scoreboard bench for lakespec_cfg_loader: default 512/32 instance plus a 550-bit truncation instance.
module tb_lakespec_cfg_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic         a_start, a_valid, a_ready, a_flush, a_loaded, a_busy;
    logic [31:0]  a_data;
    logic [511:0] a_mem;
    logic [4:0]   a_idx;
    // Instance B: 550-bit image, 18 words
    logic         b_start, b_valid, b_ready, b_flush, b_loaded, b_busy;
    logic [31:0]  b_data;
    logic [549:0] b_mem;
    logic [4:0]   b_idx;

    lakespec_cfg_loader #(.CONFIG_MEMORY_SIZE(512), .WORD_WIDTH(32), .FLUSH_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_start(a_start), .cfg_valid(a_valid), .cfg_ready(a_ready),
        .cfg_data(a_data), .config_memory(a_mem), .flush_out(a_flush), .cfg_loaded(a_loaded),
        .busy(a_busy), .word_idx(a_idx)
    );

    lakespec_cfg_loader #(.CONFIG_MEMORY_SIZE(550), .WORD_WIDTH(32), .FLUSH_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_start(b_start), .cfg_valid(b_valid), .cfg_ready(b_ready),
        .cfg_data(b_data), .config_memory(b_mem), .flush_out(b_flush), .cfg_loaded(b_loaded),
        .busy(b_busy), .word_idx(b_idx)
    );

    int checks   = 0;
    int failures = 0;

    logic [511:0] qa[$];
    logic [549:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_mem(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_img(input logic [31:0] w, input bit ramp);
        logic [511:0] img;
        for (int k = 0; k < 16; k++) img[k*32 +: 32] = ramp ? 32'(k) : w;
        return img;
    endfunction

    // Monitor A: pop expected image on each flush rise, check flush length on fall
    logic [511:0] a_exp;
    logic         a_prev = 1'b0;
    int           a_len  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev = 1'b0;
            a_len  = 0;
        end else begin
            if (a_flush && !a_prev) begin
                checks++;
                if (qa.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_commit_a actual=commit expected=none");
                end else begin
                    a_exp = qa.pop_front();
                    if (a_mem !== a_exp) begin
                        failures++;
                        $display("FAIL image_a actual=%0h expected=%0h", a_mem, a_exp);
                    end
                end
            end
            if (a_flush) a_len++;
            if (!a_flush && a_prev) begin
                checks++;
                if (a_len != 4) begin
                    failures++;
                    $display("FAIL flush_len_a actual=%0d expected=4", a_len);
                end
                a_len = 0;
            end
            a_prev = a_flush;
        end
    end

    // Monitor B: image check on flush rise
    logic [549:0] b_exp;
    logic         b_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev = 1'b0;
        end else begin
            if (b_flush && !b_prev) begin
                checks++;
                if (qb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_commit_b actual=commit expected=none");
                end else begin
                    b_exp = qb.pop_front();
                    if (b_mem !== b_exp) begin
                        failures++;
                        $display("FAIL image_b actual=%0h expected=%0h", b_mem, b_exp);
                    end
                end
            end
            b_prev = b_flush;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [31:0] d);
        if (sel) begin b_valid = 1'b1; b_data = d; end
        else     begin a_valid = 1'b1; a_data = d; end
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Called one ns after the edge that accepted the final word
    task automatic commit_check(input bit sel);
        chk("commit_ready", sel ? b_ready : a_ready, 0);
        chk("commit_busy",  sel ? b_busy  : a_busy,  1);
        chk("commit_flush", sel ? b_flush : a_flush, 0);
        tick();
        chk("flush_rise",   sel ? b_flush : a_flush, 1);
        chk("loaded",       sel ? b_loaded : a_loaded, 1);
        repeat (4) tick();
        chk("idle_busy",    sel ? b_busy  : a_busy,  0);
        chk("idle_flush",   sel ? b_flush : a_flush, 0);
    endtask

    logic [511:0] img_ramp, img_aa, img_5, img_33;

    initial begin
        rst_n = 1'b0;
        {a_start, a_valid, b_start, b_valid} = '0;
        a_data = '0;
        b_data = '0;
        img_ramp = mk_img(32'h0, 1'b1);
        img_aa   = mk_img(32'hAAAA_AAAA, 1'b0);
        img_5    = mk_img(32'h5, 1'b0);
        img_33   = mk_img(32'h33, 1'b0);

        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_idx", a_idx, 0);
        chk_mem("rst_mem", a_mem, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Truncation: 550-bit image, 18 all-ones words
        qb.push_back({550{1'b1}});
        start(1'b1);
        chk("trunc_ready", b_ready, 1);
        for (int k = 0; k < 18; k++) send(1'b1, 32'hFFFF_FFFF);
        chk("trunc_idx", b_idx, 18);
        commit_check(1'b1);

        // Basic back-to-back load
        qa.push_back(img_ramp);
        start(1'b0);
        chk("basic_ready", a_ready, 1);
        for (int k = 0; k < 16; k++) send(1'b0, 32'(k));
        chk("basic_idx", a_idx, 16);
        commit_check(1'b0);

        // Backpressure: valid alternates, garbage on idle data
        qa.push_back(img_ramp);
        start(1'b0);
        for (int k = 0; k < 16; k++) begin
            send(1'b0, 32'(k));
            if (k < 15) begin
                a_data = 32'hDEAD_BEEF;
                tick();
                chk("gap_idx", a_idx, 64'(k + 1));
            end
        end
        commit_check(1'b0);

        // Restart mid-load keeps previous image
        qa.push_back(img_aa);
        start(1'b0);
        for (int k = 0; k < 16; k++) send(1'b0, 32'hAAAA_AAAA);
        commit_check(1'b0);
        start(1'b0);
        for (int k = 0; k < 5; k++) send(1'b0, 32'h1);
        chk("restart_idx5", a_idx, 5);
        chk_mem("restart_hold1", a_mem, img_aa);
        start(1'b0);
        chk("restart_idx0", a_idx, 0);
        chk("restart_ready", a_ready, 1);
        qa.push_back(img_5);
        for (int k = 0; k < 16; k++) send(1'b0, 32'h5);
        chk_mem("restart_hold2", a_mem, img_aa);
        tick();
        chk("flush_start", a_flush, 1);
        a_start = 1'b1;
        tick();
        tick();
        chk("start_in_flush_flush", a_flush, 1);
        chk("start_in_flush_idx", a_idx, 16);
        a_start = 1'b0;
        tick();
        tick();
        chk("after_flush_busy", a_busy, 0);
        tick();
        chk("start_not_queued", a_busy, 0);

        // Start coincides with final word: restart wins
        start(1'b0);
        for (int k = 0; k < 15; k++) send(1'b0, 32'h7);
        a_start = 1'b1;
        a_valid = 1'b1;
        a_data  = 32'h7;
        tick();
        a_start = 1'b0;
        a_valid = 1'b0;
        chk("simul_idx", a_idx, 0);
        chk("simul_ready", a_ready, 1);
        tick();
        chk("simul_flush", a_flush, 0);
        chk_mem("simul_mem", a_mem, img_5);

        // Reset asserted mid-FLUSH
        start(1'b0);
        qa.push_back(img_33);
        for (int k = 0; k < 16; k++) send(1'b0, 32'h33);
        tick();
        tick();
        chk("pre_rst_flush", a_flush, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_flush", a_flush, 0);
        chk("rst_busy2", a_busy, 0);
        chk("rst_ready2", a_ready, 0);
        chk("rst_loaded", a_loaded, 0);
        chk_mem("rst_mem2", a_mem, '0);
        chk("rst_idx2", a_idx, 0);
        tick();
        rst_n = 1'b1;
        tick();

        chk("pending_a", 64'(qa.size()), 0);
        chk("pending_b", 64'(qb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
